// File: rtl/axi_rd_pkg.sv
// axi_rd_pkg: shared FSM state and fixed AXI read attributes for the read arbiter
package axi_rd_pkg;
  typedef enum logic [1:0] {IDLE, AR, R} state_t;
  localparam logic [1:0] ARBURST_INCR = 2'b01;
  localparam logic [2:0] ARSIZE_4B = 3'b010;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick; on a tie the requester not served last wins
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       vld
);
  assign vld = |req;
  assign gnt = &req ? ~last : req[1];
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read master between two requesters, one burst at a time
module axi_rd_arbiter
  import axi_rd_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_arvalid,
  input  logic [ADDR_W-1:0] req0_araddr,
  input  logic [LEN_W-1:0]  req0_arlen,
  output logic              req0_arready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req0_rready,
  input  logic              req1_arvalid,
  input  logic [ADDR_W-1:0] req1_araddr,
  input  logic [LEN_W-1:0]  req1_arlen,
  output logic              req1_arready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  input  logic              req1_rready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [LEN_W-1:0]  m_axi_arlen,
  output logic [1:0]        m_axi_arburst,
  output logic [2:0]        m_axi_arsize,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic              busy,
  output logic              grant
);
  state_t state_q, state_d;
  logic grant_q, grant_d, last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic arb_gnt, arb_vld, hs;
  rr_arb2 u_rr (
    .req ({req1_arvalid, req0_arvalid}),
    .last(last_q),
    .gnt (arb_gnt),
    .vld (arb_vld)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end
  assign hs = m_axi_rvalid & m_axi_rready;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (arb_vld) begin
        state_d = AR;
        grant_d = arb_gnt;
        addr_d  = arb_gnt ? req1_araddr : req0_araddr;
        len_d   = arb_gnt ? req1_arlen : req0_arlen;
      end
      AR: if (m_axi_arready) begin
        state_d = R;
        cnt_d   = len_q;
      end
      R: if (hs) begin
        state_d = cnt_q == '0 ? IDLE : R;
        last_d  = cnt_q == '0 ? grant_q : last_q;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy          = state_q != IDLE;
    m_axi_arvalid = state_q == AR;
    m_axi_rready  = state_q == R && (grant_q ? req1_rready : req0_rready);
    req0_arready  = !rst && state_q == IDLE && arb_vld && !arb_gnt;
    req1_arready  = !rst && state_q == IDLE && arb_vld && arb_gnt;
    req0_rvalid   = state_q == R && !grant_q && m_axi_rvalid;
    req1_rvalid   = state_q == R && grant_q && m_axi_rvalid;
    req0_rdata    = (state_q == R && !grant_q) ? m_axi_rdata : '0;
    req1_rdata    = (state_q == R && grant_q) ? m_axi_rdata : '0;
  end
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arburst = ARBURST_INCR;
  assign m_axi_arsize  = ARSIZE_4B;
  assign grant         = grant_q;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed bursts with expected AR requests and beats queued for a monitor
module tb_axi_rd_arbiter;
  logic clk = 0, rst = 1;
  logic req0_arvalid = 0, req1_arvalid = 0, req0_rready = 0, req1_rready = 0;
  logic [15:0] req0_araddr = 0, req1_araddr = 0, m_axi_araddr;
  logic [7:0] req0_arlen = 0, req1_arlen = 0, m_axi_arlen;
  logic req0_arready, req1_arready, req0_rvalid, req1_rvalid;
  logic [31:0] req0_rdata, req1_rdata, m_axi_rdata = 0;
  logic [1:0] m_axi_arburst;
  logic [2:0] m_axi_arsize;
  logic m_axi_arvalid, m_axi_arready = 0, m_axi_rvalid = 0, m_axi_rready, busy, grant;
  int checks = 0, errors = 0;
  int ar_pulses [2] = '{0, 0};
  logic prev_ar0 = 0, prev_ar1 = 0;
  logic [24:0] ar_q [$];
  logic [32:0] beat_q [$];

  axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_arvalid(req0_arvalid), .req0_araddr(req0_araddr), .req0_arlen(req0_arlen),
    .req0_arready(req0_arready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req0_rready(req0_rready),
    .req1_arvalid(req1_arvalid), .req1_araddr(req1_araddr), .req1_arlen(req1_arlen),
    .req1_arready(req1_arready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .req1_rready(req1_rready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arburst(m_axi_arburst),
    .m_axi_arsize(m_axi_arsize), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_ar0 <= 0;
      prev_ar1 <= 0;
    end else begin
      if (m_axi_arvalid && m_axi_arready) begin
        if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
        else check("ar_req", {m_axi_araddr, m_axi_arlen, grant}, ar_q.pop_front());
        check("ar_attrs", {m_axi_arburst, m_axi_arsize}, 5'b01010);
      end
      if (req0_rvalid && req0_rready) begin
        if (beat_q.size() == 0) check("beat0_unexpected", 1, 0);
        else check("beat", {1'b0, req0_rdata}, beat_q.pop_front());
      end
      if (req1_rvalid && req1_rready) begin
        if (beat_q.size() == 0) check("beat1_unexpected", 1, 0);
        else check("beat", {1'b1, req1_rdata}, beat_q.pop_front());
      end
      if (req0_rvalid && req1_rvalid) check("rvalid_both", 1, 0);
      if (req0_arready) begin
        ar_pulses[0]++;
        check("arready0_single", prev_ar0, 0);
      end
      if (req1_arready) begin
        ar_pulses[1]++;
        check("arready1_single", prev_ar1, 0);
      end
      prev_ar0 <= req0_arready;
      prev_ar1 <= req1_arready;
    end
  end

  task automatic do_reset();
    rst = 1;
    req0_arvalid = 0; req1_arvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
    req0_rready = 0; req1_rready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {busy, grant, m_axi_arvalid, m_axi_rready, req0_arready, req1_arready,
                       req0_rvalid, req1_rvalid}, 0);
    check("rst_data", |{req0_rdata, req1_rdata, m_axi_araddr, m_axi_arlen}, 0);
    check("rst_attrs", {m_axi_arburst, m_axi_arsize}, 5'b01010);
    ar_q.delete();
    beat_q.delete();
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("post_rst_ctrl", {busy, grant, m_axi_arvalid, m_axi_rready, req0_arready, req1_arready,
                            req0_rvalid, req1_rvalid}, 0);
    check("post_rst_data", |{req0_rdata, req1_rdata, m_axi_araddr, m_axi_arlen}, 0);
    @(posedge clk); #1;
  endtask

  task automatic request(input logic n, input logic [15:0] addr, input logic [7:0] len);
    bit seen = 0;
    if (n) begin req1_arvalid = 1; req1_araddr = addr; req1_arlen = len; end
    else begin req0_arvalid = 1; req0_araddr = addr; req0_arlen = len; end
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = n ? req1_arready : req0_arready;
    end
    if (!seen) check("arready_timeout", 0, 1);
    @(posedge clk); #1;
    if (n) req1_arvalid = 0; else req0_arvalid = 0;
  endtask

  task automatic serve_ar(input int delay);
    int n = 0;
    bit done = 0;
    logic [15:0] a = 0;
    logic [7:0] l = 0;
    m_axi_arready = (delay == 0);
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (m_axi_arvalid) begin
        if (n == 0) begin
          a = m_axi_araddr;
          l = m_axi_arlen;
        end else check("ar_stable", {m_axi_araddr, m_axi_arlen}, {a, l});
        n++;
        if (m_axi_arready) done = 1;
      end
      @(posedge clk); #1;
      m_axi_arready = (n >= delay) && !done;
    end
    m_axi_arready = 0;
    check("ar_hold_cycles", n, delay + 1);
  endtask

  task automatic serve_r(input int nbeats, input logic [31:0] base, input bit toggle);
    int i = 0;
    logic rr = 1;
    for (int t = 0; t < 2000 && i < nbeats; t++) begin
      m_axi_rvalid = 1;
      m_axi_rdata = base + i;
      req0_rready = rr;
      req1_rready = rr;
      @(negedge clk);
      if (toggle) check("rready_mirror", m_axi_rready, rr);
      if (m_axi_rready) i++;
      @(posedge clk); #1;
      if (toggle) rr = ~rr;
    end
    m_axi_rvalid = 0;
    req0_rready = 0;
    req1_rready = 0;
    check("beat_count", i, nbeats);
  endtask

  task automatic burst(input logic n, input logic [15:0] addr, input logic [7:0] len,
                       input int delay, input logic [31:0] base, input bit toggle);
    int p = ar_pulses[n];
    ar_q.push_back({addr, len, n});
    for (int i = 0; i <= int'(len); i++) beat_q.push_back({n, base + i});
    request(n, addr, len);
    serve_ar(delay);
    serve_r(int'(len) + 1, base, toggle);
    @(negedge clk);
    check("busy_after_last", busy, 0);
    check("arready_pulses", ar_pulses[n], p + 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int p0, p1;
    bit seen;
    do_reset();
    burst(0, 16'h0100, 8'd3, 0, 32'hA0, 0);
    do_reset();
    p0 = ar_pulses[0];
    p1 = ar_pulses[1];
    for (int k = 0; k < 4; k++) begin
      ar_q.push_back({k[0] ? 16'h2000 : 16'h1000, 8'd1, k[0]});
      for (int i = 0; i < 2; i++) beat_q.push_back({k[0], 32'hB0 + 32'(16 * k + i)});
    end
    req0_arvalid = 1; req0_araddr = 16'h1000; req0_arlen = 1;
    req1_arvalid = 1; req1_araddr = 16'h2000; req1_arlen = 1;
    for (int k = 0; k < 4; k++) begin
      serve_ar(0);
      if (k == 3) begin req0_arvalid = 0; req1_arvalid = 0; end
      serve_r(2, 32'hB0 + 32'(16 * k), 0);
    end
    check("rr_pulses0", ar_pulses[0] - p0, 2);
    check("rr_pulses1", ar_pulses[1] - p1, 2);
    @(negedge clk);
    check("rr_idle", busy, 0);
    @(posedge clk); #1;
    burst(1, 16'h0200, 8'd2, 5, 32'hC0, 0);
    burst(1, 16'h0300, 8'd7, 0, 32'hD0, 1);
    burst(0, 16'h0400, 8'd0, 0, 32'hE0, 0);
    burst(1, 16'h0500, 8'd255, 0, 32'h1000, 0);
    ar_q.push_back({16'h0600, 8'd3, 1'b0});
    beat_q.push_back({1'b0, 32'hF0});
    beat_q.push_back({1'b0, 32'hF1});
    request(0, 16'h0600, 8'd3);
    serve_ar(0);
    serve_r(2, 32'hF0, 0);
    do_reset();
    ar_q.push_back({16'h0700, 8'd0, 1'b0});
    beat_q.push_back({1'b0, 32'h77});
    req0_arvalid = 1; req0_araddr = 16'h0700; req0_arlen = 0;
    req1_arvalid = 1; req1_araddr = 16'h0800; req1_arlen = 0;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = req0_arready;
      if (seen) check("tie_not_req1", req1_arready, 0);
    end
    check("tie_req0_first", seen, 1);
    @(posedge clk); #1;
    req0_arvalid = 0;
    req1_arvalid = 0;
    serve_ar(0);
    serve_r(1, 32'h77, 0);
    repeat (2) @(posedge clk);
    check("ar_q_empty", ar_q.size(), 0);
    check("beat_q_empty", beat_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL take parameter ADDR_W, default 16, meaning AXI read address width.
REQ-002 SHALL take parameter DATA_W, default 32, meaning AXI read data width.
REQ-003 SHALL take parameter LEN_W, default 8, meaning burst length field width.
REQ-004 SHALL have port clk, input, 1 bit: clock, all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have, for N = 0 and 1, port reqN_arvalid, input, 1 bit: requester N has a burst request.
REQ-007 SHALL have, for N = 0 and 1, port reqN_araddr, input, ADDR_W bits: requester N start address.
REQ-008 SHALL have, for N = 0 and 1, port reqN_arlen, input, LEN_W bits: requester N beats minus 1.
REQ-009 SHALL have, for N = 0 and 1, port reqN_arready, output, 1 bit: request accepted.
REQ-010 SHALL have, for N = 0 and 1, port reqN_rvalid, output, 1 bit: beat valid to requester N.
REQ-011 SHALL have, for N = 0 and 1, port reqN_rdata, output, DATA_W bits: beat data to requester N.
REQ-012 SHALL have, for N = 0 and 1, port reqN_rready, input, 1 bit: requester N accepts the beat.
REQ-013 SHALL have AXI master ports m_axi_araddr, output, ADDR_W; m_axi_arlen, output, LEN_W; m_axi_arburst, output, 2; m_axi_arsize, output, 3; m_axi_arvalid, output, 1; m_axi_arready, input, 1.
REQ-014 SHALL have AXI master ports m_axi_rdata, input, DATA_W; m_axi_rvalid, input, 1; m_axi_rready, output, 1.
REQ-015 SHALL have port busy, output, 1 bit: a burst is in flight.
REQ-016 SHALL have port grant, output, 1 bit: index of the requester currently owning the channel.

Function
REQ-017 SHALL implement the FSM IDLE -> AR -> R -> IDLE, with only one burst outstanding at any time.
REQ-018 In IDLE with any reqN_arvalid: SHALL grant one requester, pulse its reqN_arready for 1 cycle, latch its addr/len into registers, set grant, and enter AR on the next cycle.
REQ-019 Arbitration SHALL be round-robin: if both requesters are valid, grant the one not served last; if only one is valid, grant it.
REQ-020 In AR: m_axi_arvalid SHALL be 1 with latched araddr/arlen held stable until m_axi_arready=1, then the FSM SHALL enter R.
REQ-021 m_axi_arburst SHALL be 2'b01 (INCR); m_axi_arsize SHALL be 3'b010 (4 bytes); both are constant.
REQ-022 In R, combinationally: m_axi_rready = req[grant]_rready; req[grant]_rvalid = m_axi_rvalid; req[grant]_rdata = m_axi_rdata.
REQ-023 The non-granted requester's rvalid SHALL be 0 at all times.
REQ-024 A LEN_W-bit down-counter SHALL load arlen on entry to R and decrement only on m_axi_rvalid & m_axi_rready.
REQ-025 A handshake with counter==0 SHALL be the last beat: go to IDLE next cycle and record grant as last-served.
REQ-026 arlen=0 SHALL give exactly 1 beat; arlen=255 SHALL give exactly 256 beats, with no counter wrap.
REQ-027 reqN_arready SHALL be 0 outside IDLE; new requests SHALL wait, and no request is dropped while its arvalid stays high.
REQ-028 busy SHALL be 1 in AR and R, and 0 in IDLE.
REQ-029 m_axi_arvalid and m_axi_rready SHALL be 0 in IDLE; m_axi_rready SHALL be 0 in AR.

Reset
REQ-030 While rst=1 and on the cycle after: state SHALL be IDLE, counter 0, grant 0, last-served 1 (so req0 wins the first tie), and every output 0 except constant arburst/arsize.
REQ-031 rst mid-burst SHALL abandon the burst with no drain; the AXI slave SHALL be reset by the same rst.

Structure
REQ-032 Shared package axi_rd_pkg SHALL hold the FSM state enum, ARBURST_INCR=2'b01 and ARSIZE_4B=3'b010.
REQ-033 Round-robin selection SHALL be one sub-module, rr_arb2 (inputs: 2 requests and last-served; outputs: grant index and valid).

Verification
REQ-034 req0 addr 0x0100 len 3, arready=1 immediately, beats 0xA0..0xA3 -> AR carries 0x0100/3/01/010; req0 gets 4 beats; req1_rvalid stays 0; busy falls after beat 4.
REQ-035 Both requesters valid continuously after reset -> grant order 0,1,0,1, with each reqN_arready a single-cycle pulse.
REQ-036 m_axi_arready low for 5 cycles -> arvalid held high with araddr/arlen stable for 6 cycles; no extra reqN_arready pulses.
REQ-037 req1 len 7 with req1_rready toggling each cycle -> m_axi_rready mirrors it; exactly 8 beats delivered in order; FSM returns to IDLE after the 8th handshake.
REQ-038 arlen=0 -> 1 beat then IDLE; arlen=255 -> exactly 256 beats then IDLE.
REQ-039 rst asserted after the 2nd beat of a 4-beat burst -> next cycle IDLE with all outputs 0; on a subsequent tie, req0 is granted first.
